serial_rx_arbiter: RTL and testbench
====================================

Name: serial_rx_arbiter

Overview:
- Shares one LSB-first serial-to-parallel deserializer among n_src serial requesters.
- Grants the datapath to one source per word, in round-robin order.
- Assembles width bits from the granted source and emits the word tagged with its source index.
- Sits between the per-lane serial receivers and the word-level consumer.

Parameters:
width, 8, bits per assembled word (>=2)
n_src, 4, number of serial requesters (>=1)
src_w, $clog2(n_src) (min 1), width of the source index (localparam)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
req  input  n_src  per-source request; held high for the whole word
serial_valid  input  n_src  per-source bit strobe
serial_data  input  n_src  per-source serial bit
grant  output  n_src  one-hot grant; all zero when idle
busy  output  1  high while a word is being assembled
parallel_valid  output  1  one-cycle pulse, word complete
parallel_data  output  width  assembled word; first received bit in bit 0
parallel_src  output  src_w  index of the source that produced parallel_data

Behaviour:
- Reset (async assert, synchronous release), all registers cleared:
  - grant=0, busy=0, parallel_valid=0, parallel_data=0, parallel_src=0
  - bit counter=0, round-robin pointer=0 (source 0 has highest priority)
- FSM states: IDLE, SHIFT. All outputs are registered.
- IDLE:
  - If any req bit is high, select the first requesting source searching from ptr upward, with wrap.
  - Next cycle: grant[sel]=1, busy=1, state=SHIFT, counter=0, ptr<=sel+1 mod n_src.
  - If no req bit is high, stay in IDLE.
- SHIFT:
  - Only the granted source's serial_valid/serial_data are sampled; all other sources are ignored.
  - Each accepted bit: shift register <= {bit, sr[width-1:1]}; counter increments.
  - Bits are taken only in cycles where grant is already high. The first bit can be accepted one cycle after req is sampled.
- Word completion (bit number width accepted at edge t):
  - At t+1: parallel_valid=1, parallel_data=full word, parallel_src=granted index, grant=0, busy=0, state=IDLE.
  - Re-arbitration happens in IDLE, so the earliest next grant is at t+2. Minimum word period is width+2 cycles.
- parallel_data and parallel_src hold their values until the next completed word. parallel_valid is high for exactly one cycle.
- Abort: if the granted source drops req in SHIFT, the partial word is discarded and the state returns to IDLE next cycle.
  - grant=0, no parallel_valid, ptr keeps its advanced value.
  - serial_valid in the same cycle as the req drop is ignored.
- Fairness: a source that keeps req high is granted at most once per n_src grants while others request.
- n_src=1: grant[0] follows req with one-cycle latency; arbitration is trivial.
- Reset mid-word: partial word is lost, no parallel_valid, and priority returns to source 0.

Optional Feature:
SER_RX_ARB_TIMEOUT_EN
- With the macro: parameter timeout (default 64) and output port timeout_err (1 bit, resets to 0).
  - In SHIFT, a cycle counter runs while the granted source's serial_valid is low, and clears on every accepted bit.
  - When it reaches timeout, the word is aborted exactly like a req drop.
  - timeout_err pulses for one cycle, aligned with grant falling.
- Without the macro: no timeout parameter, no timeout_err port, no counter. A silent source holds the grant indefinitely.

Decomposition:
- Package ser_rx_arb_pkg:
  - state enum (IDLE, SHIFT)
  - helper function returning $clog2 with minimum 1, used for src_w
- One sub-module: rr_arbiter (parameter n_src).
  - Inputs: req, ptr. Output: one-hot sel, purely combinational.
  - Pointer register and FSM stay in serial_rx_arbiter.

Test Plan:
1. width=8, n_src=4; req[2]=1; src 2 sends bits 1,0,1,0,0,1,0,1 on consecutive cycles after grant -> parallel_data=8'hA5, parallel_src=2, one-cycle parallel_valid, grant[2]=1 for exactly 8 cycles.
2. req=4'b1111 held, each source sends 8'h00+index -> grant order 0,1,2,3,0; parallel_src sequence 0,1,2,3; data 8'h00,8'h01,8'h02,8'h03.
3. Src 1 granted, src 3 toggles serial_valid/serial_data throughout; src 1 sends 8'h3C with gaps of 1-3 idle cycles -> parallel_data=8'h3C; src 3 bits have no effect.
4. Src 0 sends 4 bits then drops req -> no parallel_valid, grant=0 next cycle; then src 0 sends a full 8'hFF -> parallel_data=8'hFF (no stale bits).
5. Async rst asserted mid-cycle after 5 bits from src 2 -> all outputs 0 immediately; after release, req=4'b1100 -> src 2 granted first (ptr=0).
6. (SER_RX_ARB_TIMEOUT_EN, timeout=64) src 1 granted, sends 3 bits, then silent -> abort after 64 idle cycles, timeout_err pulses once, no parallel_valid.

Source files
------------

// File: rtl/serial_rx_arbiter_pkg.sv
// Shared types and helpers for the serial_rx_arbiter slice.
// Provides the FSM state enum and a $clog2 helper that never returns 0.
package ser_rx_arb_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 1) ? 1 : unsigned'($clog2(n));
  endfunction

endpackage

// File: rtl/serial_rx_arbiter_if.sv
// Requester/consumer-facing bundle of serial_rx_arbiter.
// timeout_err exists only when SER_RX_ARB_TIMEOUT_EN is defined.
interface serial_rx_arbiter_if
  import ser_rx_arb_pkg::*;
#(
  parameter int unsigned width = 8,
  parameter int unsigned n_src = 4
);
  localparam int unsigned src_w = clog2_min1(n_src);

  logic [n_src-1:0] req;
  logic [n_src-1:0] serial_valid;
  logic [n_src-1:0] serial_data;
  logic [n_src-1:0] grant;
  logic             busy;
  logic             parallel_valid;
  logic [width-1:0] parallel_data;
  logic [src_w-1:0] parallel_src;
`ifdef SER_RX_ARB_TIMEOUT_EN
  logic             timeout_err;

  modport master (
    output req, serial_valid, serial_data,
    input  grant, busy, parallel_valid, parallel_data, parallel_src, timeout_err
  );
  modport slave (
    input  req, serial_valid, serial_data,
    output grant, busy, parallel_valid, parallel_data, parallel_src, timeout_err
  );
`else
  modport master (
    output req, serial_valid, serial_data,
    input  grant, busy, parallel_valid, parallel_data, parallel_src
  );
  modport slave (
    input  req, serial_valid, serial_data,
    output grant, busy, parallel_valid, parallel_data, parallel_src
  );
`endif

endinterface

// File: rtl/serial_rx_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr_i, with wrap.
// Output is one-hot, or zero when nobody requests.
module rr_arbiter
  import ser_rx_arb_pkg::*;
#(
  parameter int unsigned n_src = 4,
  localparam int unsigned src_w = clog2_min1(n_src)
) (
  input  logic [n_src-1:0] req_i,
  input  logic [src_w-1:0] ptr_i,
  output logic [n_src-1:0] sel_o
);

  logic found;

  // Walk priority distance k from ptr; the first hit wins.
  always_comb begin
    sel_o = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < n_src; k++) begin
      for (int unsigned i = 0; i < n_src; i++) begin
        if (!found && req_i[i] && (i == ((32'(ptr_i) + k) % n_src))) begin
          sel_o[i] = 1'b1;
          found    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/serial_rx_arbiter.sv
// Round-robin shared LSB-first deserializer for n_src serial requesters.
// Optional feature macro: SER_RX_ARB_TIMEOUT_EN (silent-source timeout abort).
module serial_rx_arbiter
  import ser_rx_arb_pkg::*;
#(
  parameter int unsigned width = 8,
  parameter int unsigned n_src = 4
`ifdef SER_RX_ARB_TIMEOUT_EN
  , parameter int unsigned timeout = 64
`endif
) (
  input logic                clk,
  input logic                rst,
  serial_rx_arbiter_if.slave bus
);

  localparam int unsigned src_w = clog2_min1(n_src);
  localparam int unsigned cnt_w = clog2_min1(width);

  state_e           state_q;
  logic [n_src-1:0] grant_q;
  logic [src_w-1:0] ptr_q;
  logic [src_w-1:0] src_q;
  logic [cnt_w-1:0] cnt_q;
  logic [width-1:0] sr_q;
  logic [width-1:0] sr_d;
  logic [width-1:0] pdata_q;
  logic [src_w-1:0] psrc_q;
  logic             busy_q;
  logic             pv_q;

  logic [n_src-1:0] sel_c;
  logic [src_w-1:0] sel_idx_c;
  logic [src_w-1:0] ptr_d;
  logic             g_req_c;
  logic             g_valid_c;
  logic             g_data_c;
  logic             last_c;

`ifdef SER_RX_ARB_TIMEOUT_EN
  localparam int unsigned to_w = clog2_min1(timeout);
  logic [to_w-1:0] to_q;
  logic            terr_q;
  assign bus.timeout_err = terr_q;
`endif

  rr_arbiter #(.n_src(n_src)) u_rr (
    .req_i (bus.req),
    .ptr_i (ptr_q),
    .sel_o (sel_c)
  );

  // Granted-lane views via the one-hot grant mask; other lanes are ignored.
  always_comb begin
    g_req_c   = |(bus.req & grant_q);
    g_valid_c = |(bus.serial_valid & grant_q);
    g_data_c  = |(bus.serial_data & grant_q);
    sel_idx_c = '0;
    for (int unsigned i = 0; i < n_src; i++) begin
      if (sel_c[i]) sel_idx_c = src_w'(i);
    end
    ptr_d  = ((32'(sel_idx_c) + 32'd1) >= n_src) ? '0 : sel_idx_c + src_w'(1);
    sr_d   = {g_data_c, sr_q[width-1:1]};
    last_c = (cnt_q == cnt_w'(width - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
      src_q   <= '0;
      cnt_q   <= '0;
      sr_q    <= '0;
      pdata_q <= '0;
      psrc_q  <= '0;
      busy_q  <= 1'b0;
      pv_q    <= 1'b0;
`ifdef SER_RX_ARB_TIMEOUT_EN
      to_q    <= '0;
      terr_q  <= 1'b0;
`endif
    end else begin
      pv_q <= 1'b0;
`ifdef SER_RX_ARB_TIMEOUT_EN
      terr_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (|bus.req) begin
            state_q <= SHIFT;
            grant_q <= sel_c;
            busy_q  <= 1'b1;
            src_q   <= sel_idx_c;
            ptr_q   <= ptr_d;
            cnt_q   <= '0;
`ifdef SER_RX_ARB_TIMEOUT_EN
            to_q    <= '0;
`endif
          end
        end
        SHIFT: begin
          if (!g_req_c) begin
            // Source withdrew: drop the partial word, keep the advanced pointer.
            state_q <= IDLE;
            grant_q <= '0;
            busy_q  <= 1'b0;
          end else if (g_valid_c) begin
            sr_q <= sr_d;
`ifdef SER_RX_ARB_TIMEOUT_EN
            to_q <= '0;
`endif
            if (last_c) begin
              state_q <= IDLE;
              grant_q <= '0;
              busy_q  <= 1'b0;
              pv_q    <= 1'b1;
              pdata_q <= sr_d;
              psrc_q  <= src_q;
            end else begin
              cnt_q <= cnt_q + cnt_w'(1);
            end
          end
`ifdef SER_RX_ARB_TIMEOUT_EN
          else if (to_q == to_w'(timeout - 1)) begin
            state_q <= IDLE;
            grant_q <= '0;
            busy_q  <= 1'b0;
            terr_q  <= 1'b1;
          end else begin
            to_q <= to_q + to_w'(1);
          end
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.grant          = grant_q;
  assign bus.busy           = busy_q;
  assign bus.parallel_valid = pv_q;
  assign bus.parallel_data  = pdata_q;
  assign bus.parallel_src   = psrc_q;

endmodule

// File: tb/tb_serial_rx_arbiter.sv
// Directed bench for serial_rx_arbiter with a word scoreboard.
// Define SER_RX_ARB_TIMEOUT_EN to also exercise the timeout abort.
module tb_serial_rx_arbiter;
  import ser_rx_arb_pkg::*;

  localparam int unsigned W = 8;
  localparam int unsigned N = 4;

  typedef struct {
    logic [7:0] data;
    logic [1:0] src;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  serial_rx_arbiter_if #(.width(W), .n_src(N)) bus ();

  serial_rx_arbiter #(
    .width(W), .n_src(N)
`ifdef SER_RX_ARB_TIMEOUT_EN
    , .timeout(64)
`endif
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t exp_q[$];
  int   checks;
  int   errors;
  int   pv_count;
  int   grant_cycles;
  logic noise_en;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle, then score any completed word against the queue.
  task automatic tick();
    exp_t e;
    if (noise_en) begin
      bus.serial_valid[3] = 1'($urandom_range(0, 1));
      bus.serial_data[3]  = 1'($urandom_range(0, 1));
    end
    @(posedge clk);
    #1;
    if (bus.grant !== '0) grant_cycles++;
    if (bus.parallel_valid === 1'b1) begin
      pv_count++;
      if (exp_q.size() == 0) begin
        check("pv_unexpected", 32'(bus.parallel_valid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("pdata", 32'(bus.parallel_data), 32'(e.data));
        check("psrc", 32'(bus.parallel_src), 32'(e.src));
      end
    end
  endtask

  task automatic wait_grant(input int src, input string tag);
    logic [N-1:0] g;
    g = '0;
    for (int i = 0; i < 40; i++) begin
      tick();
      g = bus.grant;
      if (g != '0) break;
    end
    check(tag, 32'(g), 32'(1 << src));
  endtask

  task automatic send_bits(input int src, input logic [7:0] data, input int nbits, input bit gapped);
    for (int b = 0; b < nbits; b++) begin
      if (gapped) repeat (1 + (b % 3)) tick();
      bus.serial_valid[src] = 1'b1;
      bus.serial_data[src]  = data[b];
      tick();
      bus.serial_valid[src] = 1'b0;
      bus.serial_data[src]  = 1'b0;
    end
  endtask

  task automatic send_word(input int src, input logic [7:0] data, input bit gapped);
    exp_t e;
    e.data = data;
    e.src  = 2'(src);
    exp_q.push_back(e);
    send_bits(src, data, 8, gapped);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int pv_before;
`ifdef SER_RX_ARB_TIMEOUT_EN
    int idle;
    int terr_cnt;
    logic terr_at_fall;
`endif
    checks = 0;
    errors = 0;
    pv_count = 0;
    grant_cycles = 0;
    noise_en = 1'b0;
    rst = 1'b1;
    bus.req = '0;
    bus.serial_valid = '0;
    bus.serial_data = '0;
    tick();
    tick();

    // Reset values
    check("rst_grant", 32'(bus.grant), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_pv", 32'(bus.parallel_valid), 32'd0);
    check("rst_pdata", 32'(bus.parallel_data), 32'd0);
    check("rst_psrc", 32'(bus.parallel_src), 32'd0);
    rst = 1'b0;
    tick();

    // 1: single source, 8'hA5, grant held exactly 8 cycles
    bus.req[2] = 1'b1;
    grant_cycles = 0;
    wait_grant(2, "t1_grant");
    check("t1_busy", 32'(bus.busy), 32'd1);
    send_word(2, 8'hA5, 1'b0);
    bus.req = '0;
    tick();
    tick();
    check("t1_grant_cycles", 32'(grant_cycles), 32'd8);
    check("t1_hold_data", 32'(bus.parallel_data), 32'hA5);
    check("t1_busy_low", 32'(bus.busy), 32'd0);
    check("t1_pv_count", 32'(pv_count), 32'd1);

    // 2: all request, round-robin from source 0
    do_reset();
    pv_before = pv_count;
    bus.req = 4'b1111;
    for (int s = 0; s < 4; s++) begin
      wait_grant(s, "t2_grant");
      send_word(s, 8'(s), 1'b0);
    end
    wait_grant(0, "t2_grant_wrap");
    bus.req = '0;
    tick();
    check("t2_drop_grant", 32'(bus.grant), 32'd0);
    check("t2_pv_count", 32'(pv_count - pv_before), 32'd4);

    // 3: gapped word from src 1 while src 3 toggles noise
    bus.req = 4'b0010;
    noise_en = 1'b1;
    wait_grant(1, "t3_grant");
    send_word(1, 8'h3C, 1'b1);
    noise_en = 1'b0;
    bus.req = '0;
    bus.serial_valid = '0;
    bus.serial_data = '0;
    tick();

    // 4: abort after 4 bits, then a clean 8'hFF
    pv_before = pv_count;
    bus.req = 4'b0001;
    wait_grant(0, "t4_grant");
    send_bits(0, 8'h00, 4, 1'b0);
    bus.serial_valid[0] = 1'b1;
    bus.serial_data[0] = 1'b1;
    bus.req[0] = 1'b0;
    tick();
    bus.serial_valid[0] = 1'b0;
    bus.serial_data[0] = 1'b0;
    check("t4_abort_grant", 32'(bus.grant), 32'd0);
    check("t4_abort_busy", 32'(bus.busy), 32'd0);
    tick();
    check("t4_no_pv", 32'(pv_count - pv_before), 32'd0);
    bus.req[0] = 1'b1;
    wait_grant(0, "t4_regrant");
    send_word(0, 8'hFF, 1'b0);
    bus.req = '0;
    tick();

    // 5: async reset mid-word, then priority back to source 0
    pv_before = pv_count;
    bus.req = 4'b0100;
    wait_grant(2, "t5_grant");
    send_bits(2, 8'h1F, 5, 1'b0);
    #3 rst = 1'b1;
    #1;
    check("t5_rst_grant", 32'(bus.grant), 32'd0);
    check("t5_rst_busy", 32'(bus.busy), 32'd0);
    check("t5_rst_pv", 32'(bus.parallel_valid), 32'd0);
    check("t5_rst_pdata", 32'(bus.parallel_data), 32'd0);
    check("t5_rst_psrc", 32'(bus.parallel_src), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.req = 4'b1100;
    wait_grant(2, "t5_grant_after_rst");
    send_word(2, 8'h5A, 1'b0);
    bus.req = '0;
    tick();
    check("t5_pv_count", 32'(pv_count - pv_before), 32'd1);

`ifdef SER_RX_ARB_TIMEOUT_EN
    // 6: silent source times out after 64 idle cycles
    pv_before = pv_count;
    bus.req = 4'b0010;
    wait_grant(1, "t6_grant");
    send_bits(1, 8'h07, 3, 1'b0);
    idle = 0;
    terr_cnt = 0;
    terr_at_fall = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick();
      idle++;
      if (bus.timeout_err === 1'b1) terr_cnt++;
      if (bus.grant === '0) begin
        terr_at_fall = bus.timeout_err;
        break;
      end
    end
    bus.req = '0;
    repeat (3) begin
      tick();
      if (bus.timeout_err === 1'b1) terr_cnt++;
    end
    check("t6_idle_cycles", 32'(idle), 32'd64);
    check("t6_terr_at_fall", 32'(terr_at_fall), 32'd1);
    check("t6_terr_count", 32'(terr_cnt), 32'd1);
    check("t6_no_pv", 32'(pv_count - pv_before), 32'd0);
`endif

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
